// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad emulator: FSM states,
// row/column strobe patterns and the key-to-matrix lookup function.
package keypad_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRESS = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   localparam logic [3:0] ROW0      = 4'b1110;
   localparam logic [3:0] ROW1      = 4'b1101;
   localparam logic [3:0] ROW2      = 4'b1011;
   localparam logic [3:0] ROW3      = 4'b0111;
   localparam logic [3:0] COL_A     = 4'b1101;
   localparam logic [3:0] COL_B     = 4'b1011;
   localparam logic [3:0] COL_C     = 4'b0111;
   localparam logic [3:0] COLS_IDLE = 4'b1111;
   localparam logic [3:0] KEY_STAR  = 4'd10;
   localparam logic [3:0] KEY_HASH  = 4'd11;

   typedef struct packed {
      logic [3:0] row;
      logic [3:0] col;
      logic       legal;
   } rowcol_t;

   // Codes 12-15 map to an all-released pattern and are flagged illegal.
   function automatic rowcol_t key_to_rowcol(input logic [3:0] code);
      rowcol_t rc;
      case (code)
         4'd1:     rc = '{ROW0, COL_A, 1'b1};
         4'd2:     rc = '{ROW0, COL_B, 1'b1};
         4'd3:     rc = '{ROW0, COL_C, 1'b1};
         4'd4:     rc = '{ROW1, COL_A, 1'b1};
         4'd5:     rc = '{ROW1, COL_B, 1'b1};
         4'd6:     rc = '{ROW1, COL_C, 1'b1};
         4'd7:     rc = '{ROW2, COL_A, 1'b1};
         4'd8:     rc = '{ROW2, COL_B, 1'b1};
         4'd9:     rc = '{ROW2, COL_C, 1'b1};
         KEY_STAR: rc = '{ROW3, COL_A, 1'b1};
         4'd0:     rc = '{ROW3, COL_B, 1'b1};
         KEY_HASH: rc = '{ROW3, COL_C, 1'b1};
         default:  rc = '{COLS_IDLE, COLS_IDLE, 1'b0};
      endcase
      return rc;
   endfunction

endpackage

// File: rtl/keypad_emulator_if.sv
// Key-press request handshake between a requester and the keypad emulator.
interface keypad_emulator_if;

   logic       key_valid;
   logic [3:0] key_code;
   logic       key_ready;

   modport master (output key_valid, output key_code, input key_ready);
   modport slave  (input key_valid, input key_code, output key_ready);

endinterface

// File: rtl/keypad_matrix_map.sv
// Combinational key code to {row pattern, column pattern, legal} lookup.
import keypad_pkg::*;

module keypad_matrix_map (
   input  logic [3:0] i_code,
   output logic [3:0] o_rowpat,
   output logic [3:0] o_colpat,
   output logic       o_legal
);

   rowcol_t w_rc;

   // Table lookup shared with the package function.
   always_comb begin
      w_rc = key_to_rowcol(i_code);
   end

   assign o_rowpat = w_rc.row;
   assign o_colpat = w_rc.col;
   assign o_legal  = w_rc.legal;

endmodule

// File: rtl/keypad_emulator.sv
// Responder side of a 4x4 matrix keypad: accepts key requests and pulls the
// matching column low while the scanner strobes the key's row.
import keypad_pkg::*;

module keypad_emulator #(
   parameter int HOLD_CYCLES   = 64,
   parameter int GAP_CYCLES    = 64,
   parameter int BOUNCE_CYCLES = 0
) (
   input  logic                CLOCK_50,
   input  logic                reset_n,
   keypad_emulator_if.slave    kbus,
   input  logic [3:0]          rows,
   output logic [3:0]          cols,
   output logic                busy,
   output logic                done,
   output logic                err
);

   localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int CW      = $clog2(MAX_CYC) + 1;
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [3:0]    r_key;
   logic          r_ready;
   logic          r_busy;
   logic          r_done;
   logic          r_err;

   logic [3:0]    w_rowpat;
   logic [3:0]    w_colpat;
   logic          w_key_legal;
   logic          w_req_legal;
   logic          w_bouncing;
   logic          w_closed;
   logic [3:0]    w_cols;

   keypad_matrix_map u_map (
      .i_code   (r_key),
      .o_rowpat (w_rowpat),
      .o_colpat (w_colpat),
      .o_legal  (w_key_legal)
   );

   assign w_req_legal = key_to_rowcol(kbus.key_code).legal;

   // Chatter only exists while a bounce window is configured.
   generate
      if (BOUNCE_CYCLES > 0) begin : g_bounce
         localparam logic [CW-1:0] BOUNCE_LIM = CW'(BOUNCE_CYCLES);
         logic [CW-1:0] w_elapsed;
         assign w_elapsed  = HOLD_LAST - r_cnt;
         assign w_bouncing = (w_elapsed < BOUNCE_LIM) && w_elapsed[0];
      end else begin : g_clean
         assign w_bouncing = 1'b0;
      end
   endgenerate

   // Request/press/release sequencing with registered status outputs.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_key   <= 4'd0;
         r_ready <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (kbus.key_valid && r_ready) begin
                  if (w_req_legal) begin
                     r_key   <= kbus.key_code;
                     r_cnt   <= HOLD_LAST;
                     r_state <= ST_PRESS;
                     r_ready <= 1'b0;
                     r_busy  <= 1'b1;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
            ST_PRESS: begin
               if (r_cnt == '0) begin
                  r_cnt   <= GAP_LAST;
                  r_state <= ST_GAP;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            ST_GAP: begin
               if (r_cnt == '0) begin
                  r_state <= ST_IDLE;
                  r_ready <= 1'b1;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_ready <= 1'b1;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // No register on rows->cols so the scanner sees a coherent pair each edge.
   always_comb begin
      w_closed = (r_state == ST_PRESS) && w_key_legal && !w_bouncing;
      if (w_closed && (rows == w_rowpat)) begin
         w_cols = w_colpat;
      end else begin
         w_cols = COLS_IDLE;
      end
   end

   assign cols           = w_cols;
   assign kbus.key_ready = r_ready;
   assign busy           = r_busy;
   assign done           = r_done;
   assign err            = r_err;

endmodule
